hcms_rx: RTL

Display-side receiver for the HCMS-29xx serial interface: the far end of our HCMS transmit path. It oversamples the five display lines (data, clock, register select, chip-enable, reset), rebuilds the 4-character dot register and both control words exactly as the display latches them, and exposes them on a column read port. It sits in loopback/self-test builds, where the transmit pins are routed back into the fabric, and also serves as the synthesizable display model for benches.

---
 rtl/hcms_pkg.sv | 41 ++++
 rtl/hcms_rx_sync.sv | 33 +++
 rtl/hcms_rx.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/hcms_pkg.sv
// Shared HCMS-29xx definitions: register select codes, control-word fields,
// reset values and display geometry. Imported by both the transmit and receive sides.
package hcms_pkg;

  localparam logic HCMS_DATA_REGISTER    = 1'b0;
  localparam logic HCMS_COMMAND_REGISTER = 1'b1;

  localparam int COLS_PER_CHAR = 5;
  localparam int ROWS_PER_COL  = 8;

  // Control word layout: bit 7 selects the word, the rest is payload.
  localparam int CW_SELECT_BIT     = 7;
  localparam int CW0_NORMAL_BIT    = 6;
  localparam int CW0_PEAK_MSB      = 5;
  localparam int CW0_PEAK_LSB      = 4;
  localparam int CW0_BRIGHT_MSB    = 3;
  localparam int CW0_BRIGHT_LSB    = 0;
  localparam int CW1_DOUT_MODE_BIT = 0;
  localparam int CW1_PRESCALE_BIT  = 1;

  localparam logic [7:0] CW0_RESET = 8'h00;
  localparam logic [7:0] CW1_RESET = 8'h00;

  typedef enum logic [1:0] {
    RX_IDLE      = 2'd0,
    RX_SHIFT_DOT = 2'd1,
    RX_SHIFT_CMD = 2'd2
  } hcms_rx_state_e;

  function automatic logic cw_targets_cw1(input logic [7:0] cw);
    return cw[CW_SELECT_BIT];
  endfunction

  function automatic logic [7:0] cw_payload(input logic [7:0] cw);
    logic [7:0] p;
    p = cw;
    p[CW_SELECT_BIT] = 1'b0;
    return p;
  endfunction

endpackage

// File: rtl/hcms_rx_sync.sv
// Multi-flop synchronizer for one asynchronous HCMS line, with rise/fall detect
// on the synchronized value.
module hcms_rx_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic r_reset,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain_r;
  logic              prev_r;

  // Synchronizer chain plus one history flop for edge detection.
  always_ff @(posedge i_clk) begin
    if (r_reset) begin
      chain_r <= {STAGES{RST_VAL}};
      prev_r  <= RST_VAL;
    end else begin
      chain_r <= {chain_r[STAGES-2:0], din};
      prev_r  <= chain_r[STAGES-1];
    end
  end

  assign q    = chain_r[STAGES-1];
  assign rise = q & ~prev_r;
  assign fall = ~q & prev_r;

endmodule

// File: rtl/hcms_rx.sv
// HCMS-29xx display-side receiver: rebuilds dot latch and control words from the
// oversampled serial lines. Define HCMS_RX_ERR_EN to add frame-error reporting.
module hcms_rx
  import hcms_pkg::*;
#(
  parameter int NUM_CHARS   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                                        i_clk,
  input  logic                                        r_reset,
  input  logic                                        i_hcms_data,
  input  logic                                        i_hcms_clock,
  input  logic                                        i_hcms_regsel,
  input  logic                                        i_hcms_ncs,
  input  logic                                        i_hcms_reset,
  input  logic [$clog2(NUM_CHARS*COLS_PER_CHAR)-1:0]  i_col_addr,
  output logic [7:0]                                  o_col_data,
  output logic [7:0]                                  o_cw0,
  output logic [7:0]                                  o_cw1,
  output logic                                        o_blank,
  output logic                                        o_dot_valid,
  output logic                                        o_cw_valid
`ifdef HCMS_RX_ERR_EN
  ,
  output logic                                        o_err_frame,
  output logic [7:0]                                  o_err_count
`endif
);

  localparam int NUM_COLS = NUM_CHARS * COLS_PER_CHAR;
  localparam int DOT_BITS = NUM_COLS * ROWS_PER_COL;

  logic data_s, regsel_s, drst_s;
  logic sclk_rise_s, ncs_rise_s, ncs_fall_s;
  logic unused_edges_s;
  logic data_rise_s, data_fall_s, sclk_q_s, sclk_fall_s;
  logic regsel_rise_s, regsel_fall_s, ncs_q_s, drst_rise_s, drst_fall_s;

  hcms_rx_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_data (
    .i_clk(i_clk), .r_reset(r_reset), .din(i_hcms_data),
    .q(data_s), .rise(data_rise_s), .fall(data_fall_s));

  hcms_rx_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_clock (
    .i_clk(i_clk), .r_reset(r_reset), .din(i_hcms_clock),
    .q(sclk_q_s), .rise(sclk_rise_s), .fall(sclk_fall_s));

  hcms_rx_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_regsel (
    .i_clk(i_clk), .r_reset(r_reset), .din(i_hcms_regsel),
    .q(regsel_s), .rise(regsel_rise_s), .fall(regsel_fall_s));

  hcms_rx_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
    .i_clk(i_clk), .r_reset(r_reset), .din(i_hcms_ncs),
    .q(ncs_q_s), .rise(ncs_rise_s), .fall(ncs_fall_s));

  hcms_rx_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_reset (
    .i_clk(i_clk), .r_reset(r_reset), .din(i_hcms_reset),
    .q(drst_s), .rise(drst_rise_s), .fall(drst_fall_s));

  assign unused_edges_s = ^{data_rise_s, data_fall_s, sclk_q_s, sclk_fall_s,
                            regsel_rise_s, regsel_fall_s, ncs_q_s, drst_rise_s, drst_fall_s};

  hcms_rx_state_e state_r, state_nxt_s;
  logic shift_dot_s, shift_cmd_s, end_dot_s, end_cmd_s, start_s, abort_s;

  // State register.
  always_ff @(posedge i_clk) begin
    if (r_reset) begin
      state_r <= RX_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a low display reset forces IDLE from any state.
  always_comb begin
    state_nxt_s = state_r;
    if (!drst_s) begin
      state_nxt_s = RX_IDLE;
    end else begin
      case (state_r)
        RX_IDLE: begin
          if (ncs_fall_s) begin
            state_nxt_s = (regsel_s == HCMS_COMMAND_REGISTER) ? RX_SHIFT_CMD : RX_SHIFT_DOT;
          end else begin
            state_nxt_s = RX_IDLE;
          end
        end
        RX_SHIFT_DOT, RX_SHIFT_CMD: begin
          if (ncs_rise_s) begin
            state_nxt_s = RX_IDLE;
          end else begin
            state_nxt_s = state_r;
          end
        end
        default: state_nxt_s = RX_IDLE;
      endcase
    end
  end

  // Per-state datapath controls.
  always_comb begin
    shift_dot_s = 1'b0;
    shift_cmd_s = 1'b0;
    end_dot_s   = 1'b0;
    end_cmd_s   = 1'b0;
    start_s     = 1'b0;
    abort_s     = 1'b0;
    if (!drst_s) begin
      abort_s = (state_r != RX_IDLE);
    end else begin
      case (state_r)
        RX_IDLE:      start_s = ncs_fall_s;
        RX_SHIFT_DOT: begin
          shift_dot_s = sclk_rise_s;
          end_dot_s   = ncs_rise_s;
        end
        RX_SHIFT_CMD: begin
          shift_cmd_s = sclk_rise_s;
          end_cmd_s   = ncs_rise_s;
        end
        default: start_s = 1'b0;
      endcase
    end
  end

  logic [DOT_BITS-1:0] sr_r, sr_nxt_s, latch_r;
  logic [7:0]          cmd_r, cmd_nxt_s, cnt_r, cnt_nxt_s;
  logic [7:0]          cw0_r, cw1_r, col_r;
  logic                dot_valid_r, cw_valid_r;

  // Shift-before-latch: a shift coinciding with ncs rise is included in the latched value.
  always_comb begin
    sr_nxt_s  = shift_dot_s ? {sr_r[DOT_BITS-2:0], data_s} : sr_r;
    cmd_nxt_s = shift_cmd_s ? {cmd_r[6:0], data_s} : cmd_r;
    if ((shift_dot_s || shift_cmd_s) && (cnt_r != 8'hFF)) begin
      cnt_nxt_s = cnt_r + 8'd1;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Shift registers, dot latch, control words and update strobes.
  always_ff @(posedge i_clk) begin
    if (r_reset || !drst_s) begin
      sr_r        <= '0;
      latch_r     <= '0;
      cmd_r       <= 8'h00;
      cnt_r       <= 8'h00;
      cw0_r       <= CW0_RESET;
      cw1_r       <= CW1_RESET;
      dot_valid_r <= 1'b0;
      cw_valid_r  <= 1'b0;
    end else begin
      sr_r        <= sr_nxt_s;
      cmd_r       <= cmd_nxt_s;
      cnt_r       <= start_s ? 8'h00 : cnt_nxt_s;
      dot_valid_r <= 1'b0;
      cw_valid_r  <= 1'b0;
      if (end_dot_s && (cnt_nxt_s != 8'h00)) begin
        latch_r     <= sr_nxt_s;
        dot_valid_r <= 1'b1;
      end else begin
        latch_r     <= latch_r;
      end
      // The select bit only routes the word; it is not stored.
      if (end_cmd_s && (cnt_nxt_s >= 8'd8)) begin
        cw_valid_r <= 1'b1;
        if (cw_targets_cw1(cmd_nxt_s)) begin
          cw1_r <= cw_payload(cmd_nxt_s);
        end else begin
          cw0_r <= cw_payload(cmd_nxt_s);
        end
      end else begin
        cw0_r <= cw0_r;
      end
    end
  end

  logic [ROWS_PER_COL-1:0] col_s [NUM_COLS];

  for (genvar k = 0; k < NUM_COLS; k++) begin : g_col
    assign col_s[k] = latch_r[DOT_BITS-1-ROWS_PER_COL*k -: ROWS_PER_COL];
  end

  // Column read port; addresses beyond the chain read as blank.
  always_ff @(posedge i_clk) begin
    if (r_reset) begin
      col_r <= 8'h00;
    end else if (int'(i_col_addr) < NUM_COLS) begin
      col_r <= col_s[i_col_addr];
    end else begin
      col_r <= 8'h00;
    end
  end

  assign o_col_data  = col_r;
  assign o_cw0       = cw0_r;
  assign o_cw1       = cw1_r;
  assign o_blank     = ~cw0_r[CW0_NORMAL_BIT];
  assign o_dot_valid = dot_valid_r;
  assign o_cw_valid  = cw_valid_r;

`ifdef HCMS_RX_ERR_EN
  logic       err_s, err_frame_r;
  logic [7:0] err_cnt_r;

  always_comb begin
    err_s = abort_s
         || (end_dot_s && (cnt_nxt_s[2:0] != 3'd0))
         || (end_cmd_s && (cnt_nxt_s != 8'd8));
  end

  // Error pulse and saturating counter survive display resets.
  always_ff @(posedge i_clk) begin
    if (r_reset) begin
      err_frame_r <= 1'b0;
      err_cnt_r   <= 8'h00;
    end else begin
      err_frame_r <= err_s;
      if (err_s && (err_cnt_r != 8'hFF)) begin
        err_cnt_r <= err_cnt_r + 8'd1;
      end else begin
        err_cnt_r <= err_cnt_r;
      end
    end
  end

  assign o_err_frame = err_frame_r;
  assign o_err_count = err_cnt_r;
`endif

endmodule
